pipelined_barrel_shifter: RTL and testbench
===========================================

# pipelined_barrel_shifter

Parametrised, pipelined barrel shifter: the general successor to the fixed constant-amount shifters in the datapath. It takes a WIDTH-bit operand, a run-time shift amount and an operation code, and produces the shifted word after a fixed latency of one cycle per shift level. It has valid/ready handshakes on both sides and full-pipeline backpressure. It sits between the register-read stage and the ALU result mux. With WIDTH=64, amount 8 and op SLL it reproduces the existing 8-bit left-shift block.

## Interface
- WIDTH, 64: operand width. Must be a power of two, at least 8.
- LEVELS, $clog2(WIDTH): derived, not overridable. This is the number of shift levels and the latency.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  WIDTH  operand.
- in_amount  in  LEVELS  shift amount, 0..WIDTH-1.
- in_op  in  2  operation code: 00 SLL, 01 SRL, 10 SRA, 11 ROL (see Configuration).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  shifted result.

## Operation
- The block has LEVELS registered stages. Stage k conditionally shifts by 2^k when amount bit k is 1.
- Each stage register holds: valid, data, op, the sign bit (the MSB of the original in_data) and the remaining amount bits.
- Fill rules per op:
  - SLL: zeros enter the LSBs.
  - SRL: zeros enter the MSBs.
  - SRA: the carried sign bit enters the MSBs.
  - ROL: bits leaving the MSB re-enter at the LSB.
- An amount of 0 passes the data through unchanged, for every op.
- Amounts are modulo WIDTH by construction; no out-of-range case exists.
- Advance signal: advance = !out_valid | out_ready. All stages load on advance and hold otherwise. Bubbles are not collapsed.
- in_ready = advance. A transfer happens when in_valid & in_ready.
  - If advance is high and in_valid is low, stage 0 loads valid=0.
- out_valid and out_data come directly from the last stage register. They must be held stable while out_valid & !out_ready.
- Simultaneous output handshake and input acceptance in the same cycle is allowed, giving full throughput of one beat per cycle.

## Timing
- Reset values (asynchronous on reset_n low): every stage valid=0, data=0, op=0, sign=0, amount=0.
  - Therefore out_valid=0, out_data=0 and in_ready=1.
- Input beats during reset have no effect.
- Reset asserted mid-operation discards all in-flight beats immediately. After release, the first accepted beat has normal latency.
- Latency: a beat accepted in cycle t gives out_valid=1 with its result in cycle t+LEVELS, provided out_ready stayed high. Each stall cycle adds one cycle.
- For WIDTH=64 the latency is 6 cycles. Throughput is 1 beat/cycle when out_ready=1.
- Order is strictly preserved. There is no combinational path from in_* to out_*.
- The only combinational path is out_ready to in_ready.

## Configuration
- Macro: SHIFTER_ROTATE_EN.
- When defined: op 11 performs ROL as specified above.
- When not defined: op 11 decodes as SLL. The wrap-around mux is not synthesised.
- All other behaviour and the latency are identical with and without the macro.

## Structure
- Package shifter_pkg holds:
  - the op typedef (enum SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROL);
  - the stage-register struct (valid, data, op, sign, amount), parametrised by WIDTH through the top level.
- Sub-module shift_stage holds one level:
  - parameters WIDTH and DIST = 2^k;
  - the combinational shift/fill for all ops, followed by the stage register with the advance enable.
- The top level generates LEVELS instances of shift_stage and contains the handshake logic.

## Test plan
- Reset, then in_data=64'h0123_4567_89AB_CDEF, amount=8, SLL with out_ready=1 -> in cycle t+6 out_valid=1, out_data=64'h2345_6789_ABCD_EF00.
- SRA, in_data=64'h8000_0000_0000_00F0, amount=4 -> 64'hF800_0000_0000_000F. The same operand with SRL -> 64'h0800_0000_0000_000F.
- ROL, in_data=64'h8000_0000_0000_0001, amount=63:
  - with SHIFTER_ROTATE_EN -> 64'hC000_0000_0000_0000;
  - without the macro -> 64'h8000_0000_0000_0000.
- Stream 10 back-to-back beats, amounts 0..9 SLL on 64'h1:
  - hold out_ready=0 for 3 cycles mid-stream;
  - required: results 1<<0..1<<9 in order, none lost or duplicated, out_data stable during the stall, in_ready=0 exactly while stalled with out_valid=1.
- Assert reset_n=0 with 4 beats in flight -> out_valid=0 and in_ready=1 immediately. After release, no stale beat appears and a new beat arrives after 6 cycles.
- amount=0 for all ops on 64'hDEAD_BEEF_CAFE_F00D -> output equals input.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
// Optional rotate support is selected with SHIFTER_ROTATE_EN (see shift_stage).
package shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROL = 2'b11
  } shift_op_e;

  // Width-independent part of a stage register. The WIDTH-dependent
  // data and remaining-amount fields travel alongside it as packed
  // vectors sized by the top level, since a package struct cannot take
  // a module parameter.
  typedef struct packed {
    logic      valid;
    shift_op_e op;
    logic      sign;
  } stage_ctl_t;

endpackage

// File: rtl/shift_stage.sv
// One level of the barrel shifter: conditional shift by DIST, then a
// register that loads on advance.
// SHIFTER_ROTATE_EN: when defined, op ROL wraps MSBs into the LSBs;
// otherwise ROL decodes as SLL and no wrap mux exists.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIST  = 1,
  parameter int AMT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             advance,
  input  stage_ctl_t       ctl_d,
  input  logic [WIDTH-1:0] data_d,
  input  logic [AMT_W-1:0] amount_d,
  output stage_ctl_t       ctl_q,
  output logic [WIDTH-1:0] data_q,
  output logic [AMT_W-1:0] amount_q
);

  logic [WIDTH-1:0] shifted;

  // The amount is consumed LSB-first, so this level always looks at bit 0.
  always_comb begin
    shifted = data_d;
    if (amount_d[0]) begin
      case (ctl_d.op)
        SHIFT_SRL: shifted = {{DIST{1'b0}}, data_d[WIDTH-1:DIST]};
        SHIFT_SRA: shifted = {{DIST{ctl_d.sign}}, data_d[WIDTH-1:DIST]};
`ifdef SHIFTER_ROTATE_EN
        SHIFT_ROL: shifted = {data_d[WIDTH-1-DIST:0], data_d[WIDTH-1:WIDTH-DIST]};
`endif
        default:   shifted = {data_d[WIDTH-1-DIST:0], {DIST{1'b0}}};
      endcase
    end
  end

  // Stage register: whole pipeline moves together on advance, holds otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctl_q    <= '0;
      data_q   <= '0;
      amount_q <= '0;
    end else if (advance) begin
      ctl_q    <= ctl_d;
      data_q   <= shifted;
      amount_q <= amount_d >> 1;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: LEVELS = log2(WIDTH) registered stages,
// valid/ready on both sides with full-pipeline backpressure.
// SHIFTER_ROTATE_EN enables op ROL (otherwise ROL behaves as SLL).
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amount,
  input  logic [1:0]               in_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
);

  localparam int LEVELS = $clog2(WIDTH);

  // Index 0 is the incoming beat, index k+1 is the register of level k.
  stage_ctl_t                   ctl [LEVELS+1];
  logic [LEVELS:0][WIDTH-1:0]   data;
  logic [LEVELS:0][LEVELS-1:0]  amount;
  logic                         advance;

  // Stall only when the last stage holds a result nobody is taking.
  // Bubbles are not squeezed out, so this is the only ready path.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // On advance with no input beat, stage 0 simply loads valid=0.
  assign ctl[0]    = '{valid: in_valid, op: shift_op_e'(in_op), sign: in_data[WIDTH-1]};
  assign data[0]   = in_data;
  assign amount[0] = in_amount;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k),
      .AMT_W (LEVELS)
    ) u_stage (
      .clock    (clock),
      .reset_n  (reset_n),
      .advance  (advance),
      .ctl_d    (ctl[k]),
      .data_d   (data[k]),
      .amount_d (amount[k]),
      .ctl_q    (ctl[k+1]),
      .data_q   (data[k+1]),
      .amount_q (amount[k+1])
    );
  end

  assign out_valid = ctl[LEVELS].valid;
  assign out_data  = data[LEVELS];

  // Last-stage op/sign/amount have no consumer past the pipe.
  logic unused_tail;
  assign unused_tail = ^{amount[LEVELS], ctl[LEVELS].op, ctl[LEVELS].sign};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter (WIDTH=64, latency 6).
// Honours SHIFTER_ROTATE_EN for the ROL vector.
module tb_pipelined_barrel_shifter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [5:0]  in_amount;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  int errs   = 0;
  int checks = 0;

  pipelined_barrel_shifter #(.WIDTH(64)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Single beat with out_ready=1; checks the 6-cycle latency and the result.
  task automatic run_one(input string tag, input logic [63:0] d, input logic [5:0] a,
                         input logic [1:0] op, input logic [63:0] exp);
    int lat;
    @(posedge clock); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = d; in_amount = a; in_op = op;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!out_valid && lat < 20);
    chk({tag, "_lat"}, 64'(lat), 64'd6);
    chk(tag, out_data, exp);
  endtask

  // Stream monitor
  bit          mon_en = 0;
  bit          stall_prev = 0;
  logic [63:0] prev_data;
  int          stall_cycles = 0;
  logic [63:0] results[$];

  always @(negedge clock) begin
    if (mon_en) begin
      chk("in_ready_stall", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && !out_ready) stall_cycles++;
      if (out_valid && out_ready) results.push_back(out_data);
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    int  budget;
    int  seen;
    bit  acc;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amount = '0; in_op = '0; out_ready = 1'b1;

    // Reset state, with a beat offered during reset.
    repeat (2) @(negedge clock);
    in_valid = 1'b1; in_data = 64'hFFFF; in_amount = 6'd1;
    repeat (2) @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    reset_n = 1'b1;

    // Directed single beats.
    run_one("sll8", 64'h0123_4567_89AB_CDEF, 6'd8, 2'b00, 64'h2345_6789_ABCD_EF00);
    run_one("sra4", 64'h8000_0000_0000_00F0, 6'd4, 2'b10, 64'hF800_0000_0000_000F);
    run_one("srl4", 64'h8000_0000_0000_00F0, 6'd4, 2'b01, 64'h0800_0000_0000_000F);
`ifdef SHIFTER_ROTATE_EN
    run_one("rol63", 64'h8000_0000_0000_0001, 6'd63, 2'b11, 64'hC000_0000_0000_0000);
`else
    run_one("rol63", 64'h8000_0000_0000_0001, 6'd63, 2'b11, 64'h8000_0000_0000_0000);
`endif
    run_one("sra63", 64'h8000_0000_0000_0000, 6'd63, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF);
    run_one("srl63", 64'h8000_0000_0000_0000, 6'd63, 2'b01, 64'h0000_0000_0000_0001);
    for (int op = 0; op < 4; op++)
      run_one($sformatf("amt0_op%0d", op), 64'hDEAD_BEEF_CAFE_F00D, 6'd0, 2'(op),
              64'hDEAD_BEEF_CAFE_F00D);

    // Stream of 10 beats with a 3-cycle stall once results are flowing.
    repeat (3) @(posedge clock);
    #1;
    results.delete();
    stall_cycles = 0;
    mon_en = 1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          in_valid = 1'b1; in_data = 64'd1; in_amount = 6'(i); in_op = 2'b00;
          budget = 0;
          do begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock); #1;
            budget++;
          end while (!acc && budget < 20);
          if (!acc) chk("stream_accept_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (8) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    budget = 0;
    while (results.size() < 10 && budget < 100) begin
      @(posedge clock);
      budget++;
    end
    repeat (3) @(posedge clock);
    mon_en = 0;
    chk("stream_count", 64'(results.size()), 64'd10);
    chk("stall_cycles", 64'(stall_cycles), 64'd3);
    for (int i = 0; i < 10 && i < results.size(); i++)
      chk($sformatf("stream_%0d", i), results[i], 64'd1 << i);

    // Reset with 4 beats in flight.
    @(posedge clock); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 64'hF0; in_amount = 6'(i + 1); in_op = 2'b00;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    chk("no_stale_beats", 64'(seen), 64'd0);
    run_one("post_rst", 64'h0000_0000_0000_00FF, 6'd4, 2'b00, 64'h0000_0000_0000_0FF0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
